// File: rtl/div_5_frame_tx.sv
// Serializes a DATA_W-bit word MSB-first, then appends a 3-bit tag that makes the
// (DATA_W+3)-bit frame a nonzero multiple of 5. The tag comes from a running mod-5 remainder.
module div_5_frame_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);

  localparam int unsigned CntW = $clog2(DATA_W + 3);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StData = 2'd1;
  localparam logic [1:0] StTag  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        rem_q, rem_d;
  logic              nz_q, nz_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        tag_q, tag_d;

  logic       take;
  logic [2:0] rem_next;
  logic       nz_next;
  logic [2:0] tag_next;

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StData) || (state_q == StTag);
  assign take      = out_valid && out_ready;
  assign nz_next   = nz_q | out_bit;

  always_comb begin
    out_bit  = 1'b0;
    out_last = 1'b0;
    case (state_q)
      StData: out_bit = shift_q[DATA_W-1];
      StTag: begin
        case (cnt_q[1:0])
          2'd0:    out_bit = tag_q[2];
          2'd1:    out_bit = tag_q[1];
          default: out_bit = tag_q[0];
        endcase
        out_last = (cnt_q == CntW'(2));
      end
      default: ;
    endcase
  end

  // rem_next = (2*rem + bit) mod 5; remainders 5..7 cannot occur.
  always_comb begin
    rem_next = 3'bx;
    case ({rem_q, out_bit})
      4'b000_0: rem_next = 3'd0;
      4'b000_1: rem_next = 3'd1;
      4'b001_0: rem_next = 3'd2;
      4'b001_1: rem_next = 3'd3;
      4'b010_0: rem_next = 3'd4;
      4'b010_1: rem_next = 3'd0;
      4'b011_0: rem_next = 3'd1;
      4'b011_1: rem_next = 3'd2;
      4'b100_0: rem_next = 3'd3;
      4'b100_1: rem_next = 3'd4;
      default:  rem_next = 3'bx;
    endcase
  end

  // Tag t satisfies (8*rem + t) mod 5 == 0, i.e. t = (2*rem) mod 5.
  always_comb begin
    tag_next = 3'bx;
    case (rem_next)
      3'd0:    tag_next = 3'd0;
      3'd1:    tag_next = 3'd2;
      3'd2:    tag_next = 3'd4;
      3'd3:    tag_next = 3'd1;
      3'd4:    tag_next = 3'd3;
      default: tag_next = 3'bx;
    endcase
    if (!nz_next) tag_next = 3'd5;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    nz_d    = nz_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          shift_d = in_data;
          rem_d   = 3'd0;
          nz_d    = 1'b0;
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (take) begin
          rem_d   = rem_next;
          nz_d    = nz_next;
          shift_d = shift_q << 1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            tag_d   = tag_next;
            cnt_d   = '0;
            state_d = StTag;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StTag: begin
        if (take) begin
          if (out_last) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      rem_q   <= 3'd0;
      nz_q    <= 1'b0;
      cnt_q   <= '0;
      tag_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      nz_q    <= nz_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_div_5_frame_tx.sv
// Directed bench for div_5_frame_tx (DATA_W=8): frame contents, tags, backpressure,
// mid-frame reset and a random loopback through a serial mod-5 receiver model.
module tb_div_5_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;

  int checks   = 0;
  int failures = 0;

  logic [10:0] got;
  int          got_n;

  always #5 clk = ~clk;

  div_5_frame_tx #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one word and collects its frame. stall_at/stall_n hold out_ready low before
  // that bit index; abort_at pulses rst for one cycle before that bit index.
  task automatic send(input logic [7:0] w, input int stall_at, input int stall_n,
                      input int abort_at);
    int   guard;
    int   stall_left;
    logic hb;
    logic hl;
    bit   first;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = ~w;
    check("first_valid", 32'(out_valid), 32'd1);
    got        = '0;
    got_n      = 0;
    stall_left = stall_n;
    first      = 1'b1;
    hb         = 1'b0;
    hl         = 1'b0;
    guard      = 0;
    while (guard < 60) begin
      guard++;
      if (abort_at >= 0 && got_n == abort_at) begin
        rst = 1'b1;
        tick();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", 32'(in_ready), 32'd1);
        return;
      end
      if (stall_left > 0 && got_n == stall_at) begin
        out_ready = 1'b0;
        if (first) begin
          hb    = out_bit;
          hl    = out_last;
          first = 1'b0;
        end else begin
          check("stall_bit", 32'(out_bit), 32'(hb));
          check("stall_last", 32'(out_last), 32'(hl));
        end
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        stall_left--;
        tick();
        continue;
      end
      out_ready = 1'b1;
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      got = {got[9:0], out_bit};
      got_n++;
      check("out_last_pos", 32'(out_last), 32'(got_n == 11));
      tick();
      if (got_n == 11) break;
    end
    check("frame_len", 32'(got_n), 32'd11);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  w;
    logic [2:0]  exp_tag;
    logic [10:0] exp_frame;
    int          rrem;
    bit          rnz;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    send(8'h07, -1, 0, -1);
    check("frame_07", 32'(got), 32'(11'b0000_0111_100));
    check("value_07", 32'(got), 32'd60);

    send(8'h00, -1, 0, -1);
    check("frame_00", 32'(got), 32'(11'b0000_0000_101));

    send(8'h05, -1, 0, -1);
    check("value_05", 32'(got), 32'd40);

    send(8'hFE, -1, 0, -1);
    check("value_fe", 32'(got), 32'd2035);

    send(8'h07, 4, 3, -1);
    check("frame_07_stall", 32'(got), 32'(11'b0000_0111_100));

    send(8'hA3, -1, 0, 5);
    @(negedge clk);
    send(8'h07, -1, 0, -1);
    check("frame_07_after_abort", 32'(got), 32'(11'b0000_0111_100));

    // Loopback through an independent serial mod-5 receiver.
    for (int i = 0; i < 1000; i++) begin
      w = 8'($urandom_range(0, 255));
      send(w, -1, 0, -1);
      rrem = 0;
      rnz  = 1'b0;
      for (int b = 10; b >= 0; b--) begin
        rrem = (2 * rrem + int'(got[b])) % 5;
        rnz  = rnz | got[b];
      end
      check("rx_div5", 32'(rnz && rrem == 0), 32'd1);
      exp_tag   = (w == 8'h00) ? 3'd5 : 3'(((5 - ((int'(w) * 8) % 5)) % 5));
      exp_frame = {w, exp_tag};
      check("rx_frame", 32'(got), 32'(exp_frame));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
